// File: rtl/tcm_ram.sv
// ---------------------------------------------------------------------------
// tcm_ram - single-clock, dual-port tightly-coupled memory.
//
// Port A is a read-only fetch port, port B a byte-masked load/store port.
// Both ports are fully pipelined (one request per port per cycle) with a
// read latency of RD_LAT (1 or 2) cycles. After every reset a sequencer
// zero-fills the array one word per cycle (unless disabled or a MEMFILE
// preload is supplied); both ports hold ready low while it runs.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   init_busy              high while the zero-fill sequencer runs
//   a_valid/a_ready/a_addr port-A read request handshake and word address
//   a_rvalid/a_rdata       port-A read response (rdata holds when idle)
//   b_valid/b_ready/b_addr port-B request handshake and word address
//   b_wen/b_wdata          byte write enables (all zero = read), write data
//   b_rvalid/b_rdata       port-B read response (rdata holds when idle)
//   b_err                  one-cycle pulse for an out-of-range port-B access
//                          (read: with the response, write: one cycle later)
// ---------------------------------------------------------------------------
module tcm_ram #(
    parameter int    DATA_W         = 32,
    parameter int    DEPTH          = 256,
    parameter int    RD_LAT         = 1,
    parameter bit    A_WRITE_FIRST  = 1'b0,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string MEMFILE        = "",
    localparam int   NB             = DATA_W / 8,
    localparam int   AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              init_busy,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [AW-1:0]     a_addr,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [AW-1:0]     b_addr,
    input  logic [NB-1:0]     b_wen,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err
);

    localparam bit PRELOAD  = (MEMFILE != "");
    localparam bit DO_CLEAR = CLEAR_ON_RESET && !PRELOAD;
    // One extra bit so the range check also works when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     clr_cnt;

    // ------------------------------------------------------------------
    // Zero-fill sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= DO_CLEAR ? CLEAR : RUN;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        init_busy  = 1'b0;
        case (state)
            CLEAR: begin
                init_busy = 1'b1;
                if (clr_cnt == LAST)
                    state_next = RUN;
            end
            RUN:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign a_ready = !init_busy;
    assign b_ready = !init_busy;

    // ------------------------------------------------------------------
    // Request decode. Nothing is accepted in a cycle where resetn is low,
    // so a request coinciding with reset never produces a response.
    // ------------------------------------------------------------------
    logic a_acc, b_acc, b_wr, b_rd, a_inr, b_inr, clr_we;

    assign a_acc  = resetn && a_valid && a_ready;
    assign b_acc  = resetn && b_valid && b_ready;
    assign b_wr   = b_acc && (|b_wen);
    assign b_rd   = b_acc && !(|b_wen);
    assign a_inr  = ({1'b0, a_addr} < DEPTH_W);
    assign b_inr  = ({1'b0, b_addr} < DEPTH_W);
    assign clr_we = resetn && (state == CLEAR);

    // ------------------------------------------------------------------
    // Array write: zero-fill has the port while busy, then port B.
    // Out-of-range writes are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (b_wr && b_inr) begin
            for (int i = 0; i < NB; i++)
                if (b_wen[i])
                    mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Read words. Out-of-range addresses read as zero. With A_WRITE_FIRST
    // a same-cycle port-B write to the same word is merged into port A's
    // result byte by byte; otherwise A sees the pre-write contents.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] a_word, b_word;

    always_comb begin
        a_word = '0;
        if (a_inr) begin
            a_word = mem[a_addr];
            if (A_WRITE_FIRST && b_wr && b_inr && (b_addr == a_addr)) begin
                for (int i = 0; i < NB; i++)
                    if (b_wen[i])
                        a_word[8*i +: 8] = b_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        b_word = '0;
        if (b_inr)
            b_word = mem[b_addr];
    end

    // ------------------------------------------------------------------
    // First output stage. Data registers only load on a response so the
    // outputs hold their last value between responses.
    // ------------------------------------------------------------------
    logic              a_v1, b_v1, b_e1, b_we1;
    logic [DATA_W-1:0] a_d1, b_d1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_v1  <= 1'b0;
            a_d1  <= '0;
            b_v1  <= 1'b0;
            b_d1  <= '0;
            b_e1  <= 1'b0;
            b_we1 <= 1'b0;
        end else begin
            a_v1 <= a_acc;
            if (a_acc)
                a_d1 <= a_word;
            b_v1 <= b_rd;
            if (b_rd)
                b_d1 <= b_word;
            b_e1  <= b_rd && !b_inr;
            b_we1 <= b_wr && !b_inr;
        end
    end

    // ------------------------------------------------------------------
    // Optional second output stage. A write error is always reported one
    // cycle after the write, independent of the read latency.
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              a_v2, b_v2, b_e2;
            logic [DATA_W-1:0] a_d2, b_d2;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    a_v2 <= 1'b0;
                    a_d2 <= '0;
                    b_v2 <= 1'b0;
                    b_d2 <= '0;
                    b_e2 <= 1'b0;
                end else begin
                    a_v2 <= a_v1;
                    if (a_v1)
                        a_d2 <= a_d1;
                    b_v2 <= b_v1;
                    if (b_v1)
                        b_d2 <= b_d1;
                    b_e2 <= b_e1;
                end
            end

            assign a_rvalid = a_v2;
            assign a_rdata  = a_d2;
            assign b_rvalid = b_v2;
            assign b_rdata  = b_d2;
            assign b_err    = b_e2 | b_we1;
        end else begin : g_lat1
            assign a_rvalid = a_v1;
            assign a_rdata  = a_d1;
            assign b_rvalid = b_v1;
            assign b_rdata  = b_d1;
            assign b_err    = b_e1 | b_we1;
        end
    endgenerate

endmodule

// File: tb/tb_tcm_ram.sv
// ---------------------------------------------------------------------------
// tb_tcm_ram - directed self-checking bench for tcm_ram.
// Two instances share one stimulus stream:
//   dut0: DEPTH=256, RD_LAT=1, A_WRITE_FIRST=0
//   dut1: DEPTH=200, RD_LAT=2, A_WRITE_FIRST=1  (addresses >= 200 out of range)
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tcm_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, a_valid, b_valid;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  b_wen;
    logic [31:0] b_wdata;

    logic        init_busy0, a_ready0, a_rvalid0, b_ready0, b_rvalid0, b_err0;
    logic [31:0] a_rdata0, b_rdata0;
    logic        init_busy1, a_ready1, a_rvalid1, b_ready1, b_rvalid1, b_err1;
    logic [31:0] a_rdata1, b_rdata1;

    int n_chk  = 0;
    int n_fail = 0;

    tcm_ram #(.DATA_W(32), .DEPTH(256), .RD_LAT(1), .A_WRITE_FIRST(1'b0),
              .CLEAR_ON_RESET(1'b1), .MEMFILE("")) dut0 (
        .clk(clk), .resetn(resetn), .init_busy(init_busy0),
        .a_valid(a_valid), .a_ready(a_ready0), .a_addr(a_addr),
        .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_valid(b_valid), .b_ready(b_ready0), .b_addr(b_addr),
        .b_wen(b_wen), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid0), .b_rdata(b_rdata0), .b_err(b_err0));

    tcm_ram #(.DATA_W(32), .DEPTH(200), .RD_LAT(2), .A_WRITE_FIRST(1'b1),
              .CLEAR_ON_RESET(1'b1), .MEMFILE("")) dut1 (
        .clk(clk), .resetn(resetn), .init_busy(init_busy1),
        .a_valid(a_valid), .a_ready(a_ready1), .a_addr(a_addr),
        .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_valid(b_valid), .b_ready(b_ready1), .b_addr(b_addr),
        .b_wen(b_wen), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid1), .b_rdata(b_rdata1), .b_err(b_err1));

    // Captured responses: index 0 = dut0 at t+1, index 1 = dut1 at t+2.
    logic [31:0] cap_ad [2];
    logic [31:0] cap_bd [2];
    logic        cap_av [2];
    logic        cap_bv [2];
    logic        cap_be [2];
    logic        early_be1;   // dut1 b_err at t+1
    logic        busy_bad;
    int          c0, c1;

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    // One request on either/both ports, then capture each DUT's response slot.
    task automatic req(input logic av, input logic [7:0] aa, input logic bv,
                       input logic [7:0] ba, input logic [3:0] wen, input logic [31:0] wd);
        a_valid = av; a_addr = aa; b_valid = bv; b_addr = ba; b_wen = wen; b_wdata = wd;
        @(negedge clk);
        cap_av[0] = a_rvalid0; cap_ad[0] = a_rdata0;
        cap_bv[0] = b_rvalid0; cap_bd[0] = b_rdata0; cap_be[0] = b_err0;
        early_be1 = b_err1;
        a_valid = 1'b0; b_valid = 1'b0; b_wen = '0;
        @(negedge clk);
        cap_av[1] = a_rvalid1; cap_ad[1] = a_rdata1;
        cap_bv[1] = b_rvalid1; cap_bd[1] = b_rdata1; cap_be[1] = b_err1;
    endtask

    // Called on the negedge where resetn was just raised; measures busy length.
    task automatic count_busy(output int n0, output int n1);
        n0 = -1; n1 = -1; busy_bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!init_busy0 && n0 < 0) n0 = i;
            if (!init_busy1 && n1 < 0) n1 = i;
            if (n0 >= 0 && n1 >= 0) break;
            if ((init_busy0 && (a_ready0 || b_ready0 || a_rvalid0)) ||
                (init_busy1 && (a_ready1 || b_ready1 || a_rvalid1)))
                busy_bad = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; b_wen = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        n_chk++; if ({a_rvalid0, b_rvalid0, b_err0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0: got %b expected 000", {a_rvalid0, b_rvalid0, b_err0}); end
        n_chk++; if ({a_rvalid1, b_rvalid1, b_err1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags1: got %b expected 000", {a_rvalid1, b_rvalid1, b_err1}); end
        n_chk++; if ({a_rdata0, b_rdata0} !== 64'h0) begin n_fail++; $display("FAIL reset_data0: got %h expected 0", {a_rdata0, b_rdata0}); end
        n_chk++; if ({a_rdata1, b_rdata1} !== 64'h0) begin n_fail++; $display("FAIL reset_data1: got %h expected 0", {a_rdata1, b_rdata1}); end
        n_chk++; if ({init_busy0, init_busy1} !== 2'b11) begin n_fail++; $display("FAIL reset_busy: got %b expected 11", {init_busy0, init_busy1}); end
    endtask

    task automatic test_zero_fill();
        a_valid = 1'b1; a_addr = 8'd0;
        resetn = 1'b1;
        count_busy(c0, c1);
        a_valid = 1'b0;
        n_chk++; if (c0 != 256) begin n_fail++; $display("FAIL fill_len0: got %0d expected 256", c0); end
        n_chk++; if (c1 != 200) begin n_fail++; $display("FAIL fill_len1: got %0d expected 200", c1); end
        n_chk++; if (busy_bad !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got ready/rvalid %b during fill expected 0", busy_bad); end
        repeat (3) @(negedge clk);
        foreach (cap_ad[k]) cap_ad[k] = 'x;
        for (int j = 0; j < 3; j++) begin
            logic [7:0] ad;
            ad = (j == 0) ? 8'd0 : (j == 1) ? 8'd100 : 8'd255;
            req(1'b1, ad, 1'b0, 8'd0, 4'h0, 32'h0);
            n_chk++; if ({cap_av[0], cap_ad[0]} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL fill_read0 @%0d: got v=%b d=%h expected v=1 d=0", ad, cap_av[0], cap_ad[0]); end
            n_chk++; if ({cap_av[1], cap_ad[1]} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL fill_read1 @%0d: got v=%b d=%h expected v=1 d=0", ad, cap_av[1], cap_ad[1]); end
        end
    endtask

    task automatic test_collision();
        // Full-word write against a read of old word 0.
        req(1'b1, 8'd5, 1'b1, 8'd5, 4'hF, 32'hFFFF_FFFF);
        n_chk++; if (cap_ad[0] !== 32'h0) begin n_fail++; $display("FAIL coll_rf0: got %h expected 00000000", cap_ad[0]); end
        n_chk++; if (cap_ad[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL coll_wf1: got %h expected ffffffff", cap_ad[1]); end
        // Partial write: write-first merges only enabled bytes.
        req(1'b1, 8'd5, 1'b1, 8'd5, 4'b0011, 32'h1234_5678);
        n_chk++; if (cap_ad[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL coll_part0: got %h expected ffffffff", cap_ad[0]); end
        n_chk++; if (cap_ad[1] !== 32'hFFFF_5678) begin n_fail++; $display("FAIL coll_part1: got %h expected ffff5678", cap_ad[1]); end
        req(1'b1, 8'd5, 1'b0, 8'd0, 4'h0, 32'h0);
        n_chk++; if (cap_ad[0] !== 32'hFFFF_5678) begin n_fail++; $display("FAIL coll_after0: got %h expected ffff5678", cap_ad[0]); end
        n_chk++; if (cap_ad[1] !== 32'hFFFF_5678) begin n_fail++; $display("FAIL coll_after1: got %h expected ffff5678", cap_ad[1]); end
    endtask

    task automatic test_byte_write();
        req(1'b0, 8'd0, 1'b1, 8'h10, 4'hF, 32'h1122_3344);
        n_chk++; if ({cap_bv[0], cap_bv[1]} !== 2'b00) begin n_fail++; $display("FAIL bw_norvalid: got %b expected 00", {cap_bv[0], cap_bv[1]}); end
        // Byte lanes 0 and 2 written, read issued in the very next cycle.
        b_valid = 1'b1; b_addr = 8'h10; b_wen = 4'b0101; b_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        b_wen = 4'h0;
        @(negedge clk);
        n_chk++; if ({b_rvalid0, b_rdata0} !== {1'b1, 32'h11BB_33DD}) begin n_fail++; $display("FAIL bw_0101_0: got v=%b d=%h expected v=1 d=11bb33dd", b_rvalid0, b_rdata0); end
        b_valid = 1'b0;
        @(negedge clk);
        n_chk++; if ({b_rvalid1, b_rdata1} !== {1'b1, 32'h11BB_33DD}) begin n_fail++; $display("FAIL bw_0101_1: got v=%b d=%h expected v=1 d=11bb33dd", b_rvalid1, b_rdata1); end
        // Upper/odd lanes, read back through port A.
        req(1'b0, 8'd0, 1'b1, 8'h11, 4'hF, 32'h1122_3344);
        req(1'b0, 8'd0, 1'b1, 8'h11, 4'b1010, 32'hAABB_CCDD);
        req(1'b1, 8'h11, 1'b0, 8'd0, 4'h0, 32'h0);
        n_chk++; if (cap_ad[0] !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_1010_0: got %h expected aa22cc44", cap_ad[0]); end
        n_chk++; if (cap_ad[1] !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_1010_1: got %h expected aa22cc44", cap_ad[1]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            b_valid = 1'b1; b_addr = 8'(i); b_wen = 4'hF; b_wdata = pat(i);
            @(negedge clk);
        end
        b_valid = 1'b0; b_wen = 4'h0;
        @(negedge clk);
        // ph 0: A reads 0..15 while B writes 16..31; ph 1: A reads 16..31.
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 18; k++) begin
                logic        ev0, ev1;
                logic [31:0] ed0, ed1;
                ev0 = (k >= 1 && k <= 16);
                ev1 = (k >= 2 && k <= 17);
                ed0 = (ph == 0) ? pat(k - 1) : 32'h2000_0000 + 32'(k - 1);
                ed1 = (ph == 0) ? pat(k - 2) : 32'h2000_0000 + 32'(k - 2);
                n_chk++; if (a_rvalid0 !== ev0) begin n_fail++; $display("FAIL stream_v0 ph%0d k%0d: got %b expected %b", ph, k, a_rvalid0, ev0); end
                if (ev0) begin n_chk++; if (a_rdata0 !== ed0) begin n_fail++; $display("FAIL stream_d0 ph%0d k%0d: got %h expected %h", ph, k, a_rdata0, ed0); end end
                n_chk++; if (a_rvalid1 !== ev1) begin n_fail++; $display("FAIL stream_v1 ph%0d k%0d: got %b expected %b", ph, k, a_rvalid1, ev1); end
                if (ev1) begin n_chk++; if (a_rdata1 !== ed1) begin n_fail++; $display("FAIL stream_d1 ph%0d k%0d: got %h expected %h", ph, k, a_rdata1, ed1); end end
                if (k < 16) begin
                    a_valid = 1'b1; a_addr = 8'(ph * 16 + k);
                    b_valid = (ph == 0); b_addr = 8'(16 + k); b_wen = 4'hF; b_wdata = 32'h2000_0000 + 32'(k);
                end else begin
                    a_valid = 1'b0; b_valid = 1'b0; b_wen = 4'h0;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_out_of_range();
        req(1'b0, 8'd0, 1'b1, 8'd210, 4'h0, 32'h0);
        n_chk++; if ({cap_bv[0], cap_be[0], cap_bd[0]} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL oor_rd0: got v=%b e=%b d=%h expected v=1 e=0 d=0", cap_bv[0], cap_be[0], cap_bd[0]); end
        n_chk++; if (early_be1 !== 1'b0) begin n_fail++; $display("FAIL oor_rd_early1: got err=%b expected 0", early_be1); end
        n_chk++; if ({cap_bv[1], cap_be[1], cap_bd[1]} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL oor_rd1: got v=%b e=%b d=%h expected v=1 e=1 d=0", cap_bv[1], cap_be[1], cap_bd[1]); end
        req(1'b0, 8'd0, 1'b1, 8'd210, 4'hF, 32'hDEAD_BEEF);
        n_chk++; if (cap_be[0] !== 1'b0) begin n_fail++; $display("FAIL oor_wr0: got err=%b expected 0", cap_be[0]); end
        n_chk++; if (early_be1 !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err1: got err=%b expected 1", early_be1); end
        n_chk++; if ({cap_bv[1], cap_be[1]} !== 2'b00) begin n_fail++; $display("FAIL oor_wr_after1: got v=%b e=%b expected 00", cap_bv[1], cap_be[1]); end
        req(1'b1, 8'd210, 1'b0, 8'd0, 4'h0, 32'h0);
        n_chk++; if (cap_ad[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_ard0: got %h expected deadbeef", cap_ad[0]); end
        n_chk++; if ({cap_av[1], cap_ad[1]} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL oor_ard1: got v=%b d=%h expected v=1 d=0", cap_av[1], cap_ad[1]); end
        req(1'b0, 8'd0, 1'b1, 8'd10, 4'h0, 32'h0);
        n_chk++; if (cap_bd[1] !== pat(10)) begin n_fail++; $display("FAIL oor_alias1: got %h expected %h", cap_bd[1], pat(10)); end
        n_chk++; if (cap_bd[0] !== pat(10)) begin n_fail++; $display("FAIL oor_alias0: got %h expected %h", cap_bd[0], pat(10)); end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 8'd3;
        @(negedge clk);
        n_chk++; if ({a_rvalid0, a_rdata0} !== {1'b1, pat(3)}) begin n_fail++; $display("FAIL rst_pre0: got v=%b d=%h expected v=1 d=%h", a_rvalid0, a_rdata0, pat(3)); end
        resetn = 1'b0; a_addr = 8'd4;
        @(negedge clk);
        a_valid = 1'b0;
        n_chk++; if ({a_rvalid0, a_rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rst_flush_a: got %b expected 00", {a_rvalid0, a_rvalid1}); end
        n_chk++; if (a_rdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_data1: got %h expected 0", a_rdata1); end
        @(negedge clk);
        n_chk++; if ({a_rvalid0, a_rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rst_flush_b: got %b expected 00", {a_rvalid0, a_rvalid1}); end
        // Interrupt the zero-fill at counter 50, then let it run again in full.
        resetn = 1'b1;
        repeat (50) @(negedge clk);
        n_chk++; if ({init_busy0, init_busy1} !== 2'b11) begin n_fail++; $display("FAIL rst_midfill_busy: got %b expected 11", {init_busy0, init_busy1}); end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        a_valid = 1'b1; a_addr = 8'd0;
        resetn = 1'b1;
        count_busy(c0, c1);
        a_valid = 1'b0;
        n_chk++; if (c0 != 256) begin n_fail++; $display("FAIL refill_len0: got %0d expected 256", c0); end
        n_chk++; if (c1 != 200) begin n_fail++; $display("FAIL refill_len1: got %0d expected 200", c1); end
        n_chk++; if (busy_bad !== 1'b0) begin n_fail++; $display("FAIL refill_ready: got %b expected 0", busy_bad); end
        repeat (3) @(negedge clk);
        req(1'b1, 8'd5, 1'b0, 8'd0, 4'h0, 32'h0);
        n_chk++; if ({cap_ad[0], cap_ad[1]} !== 64'h0) begin n_fail++; $display("FAIL refill_data: got %h expected 0", {cap_ad[0], cap_ad[1]}); end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_collision();
        test_byte_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1, "timeout");
    end

endmodule
